// File: rtl/ksa_pkg.sv
// Shared definitions for the RC4 key-scheduling engine: FSM state encoding
// and default geometry.
package ksa_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int KEY_BYTES_DEF = 3;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    READ_I,
    LATCH_I,
    READ_J,
    LATCH_J,
    WRITE_I,
    WRITE_J,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine driving a single-port S-array RAM with
// one-cycle read latency; optional identity-fill pass before the swap pass.
module ksa_engine
  import ksa_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   CLOCK_50,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [ADDR_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [ADDR_W-1:0]      mem_q,
  output logic                   busy,
  output logic                   done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  ksa_state_t state, state_nxt;
  logic [ADDR_W-1:0]      i, i_nxt, j, j_nxt, si, si_nxt, sj, sj_nxt;
  logic [KW-1:0]          k, k_nxt;
  logic [8*KEY_BYTES-1:0] key_r, key_nxt;
  logic [ADDR_W-1:0]      key_lo;
  logic [ADDR_W-1:0]      addr_nxt, wdata_nxt;
  logic                   wren_nxt, busy_nxt, done_nxt;

  // Byte 0 is the most significant key byte; only its low ADDR_W bits feed j.
  always_comb key_lo = key_r[8*(KEY_BYTES-1-int'(k)) +: ADDR_W];

  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    si_nxt    = si;
    sj_nxt    = sj;
    key_nxt   = key_r;
    addr_nxt  = '0;
    wdata_nxt = '0;
    wren_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: if (start) begin
        key_nxt   = key;
        i_nxt     = '0;
        j_nxt     = '0;
        k_nxt     = '0;
        state_nxt = init_en ? INIT : READ_I;
      end
      INIT: begin
        if (i == '1) begin
          i_nxt     = '0;
          state_nxt = READ_I;
        end else begin
          i_nxt = i + 1'b1;
        end
      end
      READ_I:  state_nxt = LATCH_I;
      LATCH_I: begin
        si_nxt    = mem_q;
        j_nxt     = j + mem_q + key_lo;
        state_nxt = READ_J;
      end
      READ_J:  state_nxt = LATCH_J;
      LATCH_J: begin
        sj_nxt    = mem_q;
        state_nxt = WRITE_I;
      end
      WRITE_I: state_nxt = WRITE_J;
      WRITE_J: begin
        if (i == '1) begin
          state_nxt = DONE;
        end else begin
          i_nxt     = i + 1'b1;
          k_nxt     = (k == K_LAST) ? '0 : k + 1'b1;
          state_nxt = READ_I;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next-state decode so they stay
    // aligned with the state they belong to without any input-to-output path.
    case (state_nxt)
      INIT: begin
        addr_nxt  = i_nxt;
        wdata_nxt = i_nxt;
        wren_nxt  = 1'b1;
        busy_nxt  = 1'b1;
      end
      READ_I: begin
        addr_nxt = i_nxt;
        busy_nxt = 1'b1;
      end
      READ_J: begin
        addr_nxt = j_nxt;
        busy_nxt = 1'b1;
      end
      LATCH_I, LATCH_J: busy_nxt = 1'b1;
      WRITE_I: begin
        addr_nxt  = i_nxt;
        wdata_nxt = sj_nxt;
        wren_nxt  = 1'b1;
        busy_nxt  = 1'b1;
      end
      WRITE_J: begin
        addr_nxt  = j_nxt;
        wdata_nxt = si_nxt;
        wren_nxt  = 1'b1;
        busy_nxt  = 1'b1;
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      key_r     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      i         <= i_nxt;
      j         <= j_nxt;
      k         <= k_nxt;
      si        <= si_nxt;
      sj        <= sj_nxt;
      key_r     <= key_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_wren  <= wren_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ksa_engine.sv
// Directed bench for ksa_engine: default 256-entry instance plus a
// 16-entry single-key-byte instance, each with a one-cycle-latency RAM model.
module tb_ksa_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, init8 = 1'b0, start4 = 1'b0, init4 = 1'b0;
  logic [23:0] key8 = '0;
  logic [7:0]  key4 = '0;
  logic [7:0]  addr8, wdata8, q8;
  logic        wren8, busy8, done8;
  logic [3:0]  addr4, wdata4, q4;
  logic        wren4, busy4, done4;
  logic [7:0]  ram8 [256];
  logic [3:0]  ram4 [16];
  logic [7:0]  gold [256];
  logic        pre_req = 1'b0;
  logic [15:0] wlog8 [$];
  logic [7:0]  wlog4 [$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  ksa_engine dut8 (
    .CLOCK_50 (clk),    .rst_n   (rst_n),  .start    (start8), .init_en (init8),
    .key      (key8),   .mem_addr(addr8),  .mem_wdata(wdata8), .mem_wren(wren8),
    .mem_q    (q8),     .busy    (busy8),  .done     (done8)
  );

  ksa_engine #(.ADDR_W(4), .KEY_BYTES(1)) dut4 (
    .CLOCK_50 (clk),    .rst_n   (rst_n),  .start    (start4), .init_en (init4),
    .key      (key4),   .mem_addr(addr4),  .mem_wdata(wdata4), .mem_wren(wren4),
    .mem_q    (q4),     .busy    (busy4),  .done     (done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_req) begin
      for (int a = 0; a < 256; a++) ram8[a] <= 8'(255 - a);
    end else if (wren8) begin
      ram8[addr8] <= wdata8;
    end
    q8 <= ram8[addr8];
    if (wren4) ram4[addr4] <= wdata4;
    q4 <= ram4[addr4];
  end

  always @(negedge clk) begin
    if (wren8) wlog8.push_back({addr8, wdata8});
    if (wren4) wlog4.push_back({addr4, wdata4});
    if (done8) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(input int c0, output int lat);
    while (done8 !== 1'b1 && (cyc - c0) < 4000) tick();
    lat = cyc - c0 + 1;
  endtask

  task automatic wait_done4(input int c0, output int lat);
    while (done4 !== 1'b1 && (cyc - c0) < 4000) tick();
    lat = cyc - c0 + 1;
  endtask

  task automatic snapshot();
    for (int a = 0; a < 256; a++) gold[a] = ram8[a];
  endtask

  // Reference RC4 KSA applied to gold[] (which holds the pre-run RAM image).
  task automatic run_gold(input bit ie, input logic [23:0] kk);
    int unsigned jj;
    logic [7:0] kb, t;
    if (ie) for (int a = 0; a < 256; a++) gold[a] = 8'(a);
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      kb = 8'(kk >> (8 * (2 - (a % 3))));
      jj = (jj + gold[a] + kb) % 256;
      t = gold[a];
      gold[a] = gold[jj];
      gold[jj] = t;
    end
  endtask

  task automatic start8_run(input bit ie, output int c0);
    init8 = ie;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    c0 = cyc;
  endtask

  initial begin
    int c0, c1, lat, base, dc0;

    tick();
    tick();
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_wren8", wren8, 0);
    check("rst_addr8", addr8, 0);
    check("rst_busy4", busy4, 0);
    rst_n = 1'b1;
    tick();

    // Identity fill with all-zero key, then the first swaps.
    base = wlog8.size();
    key8 = 24'h000000;
    start8_run(1'b1, c0);
    check("a_busy", busy8, 1);
    check("a_init_w0", {addr8, wdata8, wren8}, {8'd0, 8'd0, 1'b1});
    wait_done8(c0, lat);
    check("a_latency", lat, 1793);
    check("a_done_busy", busy8, 0);
    tick();
    check("a_done_pulse", done8, 0);
    check("a_writes", wlog8.size() - base, 768);
    for (int a = 0; a < 256; a++) check("a_init_w", wlog8[base + a], {8'(a), 8'(a)});
    check("a_swap_s2", wlog8[base + 260], 16'h0203);
    check("a_swap_s3", wlog8[base + 261], 16'h0302);

    // Narrow instance: first swap moves 5 into S[0] and 0 into S[5].
    base = wlog4.size();
    key4 = 8'h05;
    init4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    c0 = cyc;
    wait_done4(c0, lat);
    check("b_latency", lat, 113);
    tick();
    check("b_writes", wlog4.size() - base, 48);
    check("b_swap_s0", wlog4[base + 16], 8'h05);
    check("b_swap_s5", wlog4[base + 17], 8'h50);

    // Full keyed run against the reference model.
    key8 = 24'h4A2B1C;
    snapshot();
    start8_run(1'b1, c0);
    wait_done8(c0, lat);
    check("c_latency", lat, 1793);
    tick();
    run_gold(1'b1, key8);
    for (int a = 0; a < 256; a++) check("c_ram", ram8[a], gold[a]);

    // Swap-only run over a preloaded reversed array.
    pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
    check("d_preload", ram8[0], 8'hFF);
    snapshot();
    base = wlog8.size();
    start8_run(1'b0, c0);
    wait_done8(c0, lat);
    check("d_latency", lat, 1537);
    tick();
    check("d_writes", wlog8.size() - base, 512);
    check("d_first_w", wlog8[base], 16'h00B6);
    run_gold(1'b0, key8);
    for (int a = 0; a < 256; a++) check("d_ram", ram8[a], gold[a]);

    // Mid-run start pulse, then start held through DONE.
    dc0 = done_cnt;
    start8_run(1'b0, c0);
    repeat (100) tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    while ((cyc - c0) < 1530) tick();
    start8 = 1'b1;
    wait_done8(c0, lat);
    check("e_latency", lat, 1537);
    tick();
    check("e_idle_after_done", busy8, 0);
    tick();
    check("e_restart_busy", busy8, 1);
    c1 = cyc;
    start8 = 1'b0;
    wait_done8(c1, lat);
    check("e_latency2", lat, 1537);
    tick();
    tick();
    check("e_done_count", done_cnt - dc0, 2);

    // Reset partway through a run, then a clean restart.
    dc0 = done_cnt;
    start8_run(1'b1, c0);
    while ((cyc - c0) < 699) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("f_busy", busy8, 0);
    check("f_wren", wren8, 0);
    check("f_done", done8, 0);
    check("f_addr", addr8, 0);
    repeat (1200) tick();
    check("f_no_done", done_cnt - dc0, 0);
    snapshot();
    start8_run(1'b1, c0);
    wait_done8(c0, lat);
    check("f_latency", lat, 1793);
    tick();
    run_gold(1'b1, key8);
    for (int a = 0; a < 256; a++) check("f_ram", ram8[a], gold[a]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ksa_engine.md
KSA_ENGINE -- requirements
Module: ksa_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning S-array index/data width; legal range 4..8; N = 2**ADDR_W entries.
REQ-002 SHALL have parameter KEY_BYTES, default 3, meaning key length in bytes; legal range 1..32.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port init_en  input  1  1 = run init phase (S[i]=i) before the swap phase; 0 = swap phase only.
REQ-007 SHALL have port key  input  8*KEY_BYTES  key; byte 0 = most significant byte.
REQ-008 SHALL have port mem_addr  output  ADDR_W  S-RAM address.
REQ-009 SHALL have port mem_wdata  output  ADDR_W  S-RAM write data.
REQ-010 SHALL have port mem_wren  output  1  S-RAM write enable.
REQ-011 SHALL have port mem_q  input  ADDR_W  S-RAM read data, valid the cycle after mem_addr is presented with mem_wren=0.
REQ-012 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-013 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-014 SHALL implement the states IDLE, INIT, READ_I, LATCH_I, READ_J, LATCH_J, WRITE_I, WRITE_J, DONE, one state per cycle.
REQ-015 SHALL, in IDLE with start=1: latch key and init_en, clear i, j and the key index k, then go to INIT if init_en=1, else to READ_I.
REQ-016 SHALL, in INIT: drive addr=i, wdata=i, wren=1; at i=N-1 clear i and go to READ_I, otherwise increment i.
REQ-017 SHALL, in READ_I: drive addr=i, wren=0.
REQ-018 SHALL, in LATCH_I: store si=mem_q and set j = (j + mem_q + key byte k) mod N, using the low ADDR_W bits of the key byte.
REQ-019 SHALL, in READ_J: drive addr=j, wren=0.
REQ-020 SHALL, in LATCH_J: store sj=mem_q.
REQ-021 SHALL, in WRITE_I: drive addr=i, wdata=sj, wren=1.
REQ-022 SHALL, in WRITE_J: drive addr=j, wdata=si, wren=1; at i=N-1 go to DONE, otherwise increment i, step k and go to READ_I.
REQ-023 SHALL track k as a counter wrapping at KEY_BYTES-1 to N... to 0, equal to i mod KEY_BYTES; no divider.
REQ-024 SHALL, when i=j, perform both writes to the same address; the final value is unchanged and this is legal.
REQ-025 SHALL, in DONE: assert done=1 for one cycle with busy=0, then return to IDLE.
REQ-026 SHALL give a start-to-done latency of 7N+1 cycles with init_en=1 and 6N+1 cycles with init_en=0, counted from the start-sampling edge.
REQ-027 SHALL ignore start outside IDLE, including in the DONE cycle; a start held high is accepted in the first IDLE cycle.
REQ-028 SHALL keep mem_wren=0 in IDLE, READ_*, LATCH_* and DONE.
REQ-029 SHALL decode all outputs from state and registers only, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, on rst_n=0 at a clock edge, enter IDLE and clear i, j, k, si, sj, mem_addr, mem_wdata, mem_wren, busy and done, including mid-operation.
REQ-031 SHALL NOT issue done for an operation aborted by reset; RAM contents are then undefined.

Structure
REQ-032 SHALL take the state enum and the default ADDR_W and KEY_BYTES constants from a shared package ksa_pkg.
REQ-033 SHALL be a single module with no sub-module; key-byte selection is an indexed part-select.

Verification
REQ-034 SHALL cover: defaults, init_en=1, key 24'h000000 -> 256 writes with addr=data=0..255; after 3 swap iterations S[2]=3 and S[3]=2; done at cycle 1793.
REQ-035 SHALL cover: ADDR_W=4, KEY_BYTES=1, key 8'h05, init_en=1 -> first swap writes S[0]=5 and S[5]=0; done at cycle 113.
REQ-036 SHALL cover: defaults, key 24'h4A2B1C, full run -> the final 256-entry RAM matches a golden RC4 KSA model.
REQ-037 SHALL cover: init_en=0 with a preloaded RAM -> no INIT writes; done at cycle 1537.
REQ-038 SHALL cover: start pulsed while busy, and start held through DONE -> the mid-run pulse is ignored and exactly one new run starts in the next IDLE cycle.
REQ-039 SHALL cover: rst_n=0 for 1 cycle at cycle 700 -> next cycle busy=0, mem_wren=0, no done, and a restart completes normally.
